// File: rtl/sha_mem_pkg.sv
// sha_mem_pkg: shared types and constants for the SHA-256 memory responder.
// Optional feature macro (used by sha_mem_responder): SHA_MEM_HASH_CAPTURE_EN.
package sha_mem_pkg;

    // Hash capture state machine encoding
    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_COLLECT = 2'd1,
        CAP_DONE    = 2'd2
    } cap_state_e;

    // Number of 32-bit hash words h0..h7
    localparam int HASH_WORDS = 8;

    // Largest supported READ_LATENCY
    localparam int MAX_READ_LATENCY = 4;

    // True when a 16-bit word address falls inside an array of 'depth' words
    function automatic logic addr_ok(input logic [15:0] addr, input logic [31:0] depth);
        return ({16'h0000, addr} < depth);
    endfunction

endpackage

// File: rtl/sha_mem_rd_pipe.sv
// sha_mem_rd_pipe: fixed-length delay line carrying a data word and a valid bit.
// Stage 0 captures the input on the sampling edge; the output is the last stage.
module sha_mem_rd_pipe
    import sha_mem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]   data_r [LATENCY];
    logic [LATENCY-1:0] valid_r;

    // Shift data and valid one stage per clock; reset flushes every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i]  <= {WIDTH{1'b0}};
                valid_r[i] <= 1'b0;
            end
        end else begin
            data_r[0]  <= in_data;
            valid_r[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/sha_mem_responder.sv
// sha_mem_responder: word-addressed memory serving the SHA-256 initiator port,
// with a host request/grant port for preload/readback and an optional
// hash write-back capture (enabled by defining SHA_MEM_HASH_CAPTURE_EN).
// Reads are read-first: the word is taken from the array at the sampling edge
// and then delayed READ_LATENCY further edges before it appears on the outputs.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int          DEPTH        = 512,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] HASH_BASE    = 16'h0100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sha_busy,
    input  logic         enable_write,
    input  logic [15:0]  memory_addr,
    input  logic [31:0]  memory_write_data,
    output logic [31:0]  memory_read_data,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [15:0]  host_addr,
    input  logic [31:0]  host_wdata,
    output logic         host_gnt,
    output logic         host_rvalid,
    output logic [31:0]  host_rdata,
    output logic         hash_valid,
    output logic [255:0] hash_out,
    output logic         addr_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    // Reject configurations whose latency or hash window cannot be served
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
        (32'(HASH_BASE) + 32'(HASH_WORDS)) > DEPTH_L) begin : g_cfg_err
        $error("sha_mem_responder: READ_LATENCY or HASH_BASE out of range");
    end

    logic [31:0]   mem_r [DEPTH];

    logic          init_ok_s;
    logic          host_ok_s;
    logic          host_gnt_s;
    logic          host_rd_s;
    logic          init_wr_s;
    logic          host_wr_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [31:0]   wr_data_s;
    logic [31:0]   init_word_s;
    logic [31:0]   host_word_s;
    logic          init_vld_s;
    logic [31:0]   init_data_s;
    logic          addr_err_r;

    assign init_ok_s  = addr_ok(memory_addr, DEPTH_L);
    assign host_ok_s  = addr_ok(host_addr, DEPTH_L);
    assign host_gnt_s = host_req & ~sha_busy;
    assign host_rd_s  = host_gnt_s & ~host_we;
    assign init_wr_s  = enable_write & init_ok_s;
    // The initiator always wins a write collision; the host write is dropped
    assign host_wr_s  = host_gnt_s & host_we & host_ok_s & ~enable_write;
    assign host_gnt   = host_gnt_s;

    // Select the single write that reaches the array this cycle
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = {AW{1'b0}};
        wr_data_s = 32'h0000_0000;
        if (init_wr_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = memory_addr[AW-1:0];
            wr_data_s = memory_write_data;
        end else if (host_wr_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = host_addr[AW-1:0];
            wr_data_s = host_wdata;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Array write port; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Read-first word lookup for both ports; out-of-range reads yield zero
    always_comb begin
        init_word_s = 32'h0000_0000;
        host_word_s = 32'h0000_0000;
        if (init_ok_s) begin
            init_word_s = mem_r[memory_addr[AW-1:0]];
        end else begin
            init_word_s = 32'h0000_0000;
        end
        if (host_rd_s && host_ok_s) begin
            host_word_s = mem_r[host_addr[AW-1:0]];
        end else begin
            host_word_s = 32'h0000_0000;
        end
    end

    sha_mem_rd_pipe #(
        .WIDTH   (32),
        .LATENCY (READ_LATENCY + 1)
    ) u_init_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (1'b1),
        .in_data   (init_word_s),
        .out_valid (init_vld_s),
        .out_data  (init_data_s)
    );

    sha_mem_rd_pipe #(
        .WIDTH   (32),
        .LATENCY (READ_LATENCY + 1)
    ) u_host_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (host_rd_s),
        .in_data   (host_word_s),
        .out_valid (host_rvalid),
        .out_data  (host_rdata)
    );

    // A flushed pipeline stage shows zero until real data has propagated
    assign memory_read_data = init_vld_s ? init_data_s : 32'h0000_0000;

    // Sticky flag for any out-of-range access on either port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_r <= 1'b0;
        end else if (!init_ok_s || (host_gnt_s && !host_ok_s)) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign addr_err = addr_err_r;

`ifdef SHA_MEM_HASH_CAPTURE_EN
    cap_state_e    cap_state_r;
    cap_state_e    cap_state_s;
    logic [7:0]    cap_mask_r;
    logic [7:0]    cap_mask_s;
    logic [7:0]    mask_upd_s;
    logic [255:0]  hash_out_r;
    logic [255:0]  hash_out_s;
    logic [255:0]  hash_upd_s;
    logic          hash_valid_r;
    logic          hash_valid_s;
    logic          sha_busy_d_r;
    logic          win_wr_s;
    logic [2:0]    win_off_s;
    logic          busy_fall_s;
    logic          busy_rise_s;

    // Only initiator writes feed capture; host writes touch memory alone
    assign win_wr_s    = enable_write &&
                         (memory_addr >= HASH_BASE) &&
                         (memory_addr < (HASH_BASE + 16'(HASH_WORDS)));
    assign win_off_s   = 3'(memory_addr - HASH_BASE);
    assign busy_fall_s = sha_busy_d_r & ~sha_busy;
    assign busy_rise_s = ~sha_busy_d_r & sha_busy;
    assign mask_upd_s  = cap_mask_r | (8'd1 << win_off_s);

    // Captured hash vector with the current window write merged in (h0 at the MSBs)
    always_comb begin
        hash_upd_s = hash_out_r;
        for (int i = 0; i < HASH_WORDS; i++) begin
            if (win_off_s == 3'(i)) begin
                hash_upd_s[255-32*i -: 32] = memory_write_data;
            end else begin
                hash_upd_s[255-32*i -: 32] = hash_out_r[255-32*i -: 32];
            end
        end
    end

    // Capture FSM next-state, mask, hash word and pulse logic
    always_comb begin
        cap_state_s  = cap_state_r;
        cap_mask_s   = cap_mask_r;
        hash_out_s   = hash_out_r;
        hash_valid_s = 1'b0;
        case (cap_state_r)
            CAP_IDLE: begin
                if (win_wr_s) begin
                    cap_state_s = CAP_COLLECT;
                    cap_mask_s  = mask_upd_s;
                    hash_out_s  = hash_upd_s;
                end else begin
                    cap_state_s = CAP_IDLE;
                end
            end
            CAP_COLLECT: begin
                if (busy_fall_s) begin
                    cap_state_s = CAP_IDLE;
                    cap_mask_s  = 8'h00;
                end else if (win_wr_s) begin
                    cap_mask_s = mask_upd_s;
                    hash_out_s = hash_upd_s;
                    if (mask_upd_s == 8'hFF) begin
                        cap_state_s  = CAP_DONE;
                        hash_valid_s = 1'b1;
                    end else begin
                        cap_state_s = CAP_COLLECT;
                    end
                end else begin
                    cap_state_s = CAP_COLLECT;
                end
            end
            CAP_DONE: begin
                if (busy_fall_s || busy_rise_s) begin
                    cap_state_s = CAP_IDLE;
                    cap_mask_s  = 8'h00;
                end else begin
                    cap_state_s = CAP_DONE;
                end
            end
            default: begin
                cap_state_s = CAP_IDLE;
                cap_mask_s  = 8'h00;
            end
        endcase
    end

    // Capture FSM state, mask, hash vector, pulse and busy-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state_r  <= CAP_IDLE;
            cap_mask_r   <= 8'h00;
            hash_out_r   <= 256'h0;
            hash_valid_r <= 1'b0;
            sha_busy_d_r <= 1'b0;
        end else begin
            cap_state_r  <= cap_state_s;
            cap_mask_r   <= cap_mask_s;
            hash_out_r   <= hash_out_s;
            hash_valid_r <= hash_valid_s;
            sha_busy_d_r <= sha_busy;
        end
    end

    assign hash_valid = hash_valid_r;
    assign hash_out   = hash_out_r;
`else
    assign hash_valid = 1'b0;
    assign hash_out   = 256'h0;
`endif

endmodule
